// File: rtl/serial_adder_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : serial_adder_pkg                                                 |
// | Purpose  : Shared state and mode encodings for the digit-serial add/sub.    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sa_state_t;

  localparam logic c_MODE_ADD = 1'b0;
  localparam logic c_MODE_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_full_adder_bit.sv
// +----------------------------------------------------------------------------+
// | Module   : serial_full_adder_bit                                            |
// | Purpose  : One-bit full-adder cell, plain gate expressions only.            |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

`default_nettype wire

// File: rtl/digit_serial_add_sub.sv
// +----------------------------------------------------------------------------+
// | Module   : digit_serial_add_sub                                             |
// | Purpose  : Framed digit-serial adder/subtractor, LSB digit first, 1-cycle   |
// |            registered latency. SERIAL_ADDER_OVF_EN adds a signed-overflow   |
// |            output (ovf) on the last digit of each frame.                    |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module digit_serial_add_sub
  import serial_adder_pkg::*;
#(
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_last,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               out_valid,
  output logic               out_last,
  output logic [DIGIT_W-1:0] sum,
  output logic               carry_out,
`ifdef SERIAL_ADDER_OVF_EN
  output logic               ovf,
`endif
  output logic               frame_err
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  sa_state_t          r_state, w_nxt_state;
  logic               r_carry, w_nxt_carry;
  logic               r_mode, w_nxt_mode;
  logic [CNT_W-1:0]   r_count, w_nxt_count;
  logic               r_out_valid, w_nxt_out_valid;
  logic               r_out_last, w_nxt_out_last;
  logic [DIGIT_W-1:0] r_sum, w_nxt_sum;
  logic               r_carry_out, w_nxt_carry_out;
  logic               r_frame_err, w_nxt_frame_err;
  logic               r_ovf, w_nxt_ovf;

  logic               w_mode_eff;
  logic [DIGIT_W-1:0] w_b_eff;
  logic [DIGIT_W:0]   w_c;
  logic [DIGIT_W-1:0] w_sum;
  logic [CNT_W:0]     w_count_inc;
  logic               w_at_max;

  // A first beat uses its own sub input; later beats use the latched frame mode.
  assign w_mode_eff = in_first ? sub : r_mode;
  assign w_b_eff    = (w_mode_eff == c_MODE_SUB) ? ~b : b;
  assign w_c[0]     = in_first ? (sub == c_MODE_SUB) : r_carry;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_bit
    serial_full_adder_bit u_fa (
      .a    (a[i]),
      .b    (w_b_eff[i]),
      .cin  (w_c[i]),
      .s    (w_sum[i]),
      .cout (w_c[i+1])
    );
  end

  assign w_count_inc = {1'b0, r_count} + (CNT_W + 1)'(1);
  assign w_at_max    = (w_count_inc >= (CNT_W + 1)'(MAX_DIGITS));

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_carry     = r_carry;
    w_nxt_mode      = r_mode;
    w_nxt_count     = r_count;
    w_nxt_out_valid = 1'b0;
    w_nxt_out_last  = 1'b0;
    w_nxt_sum       = '0;
    w_nxt_carry_out = 1'b0;
    w_nxt_frame_err = 1'b0;
    w_nxt_ovf       = 1'b0;

    if (in_valid) begin
      if (in_first) begin
        // A first beat while busy abandons the old frame and starts afresh.
        w_nxt_frame_err = (r_state == BUSY);
        w_nxt_mode      = sub;
        w_nxt_carry     = w_c[DIGIT_W];
        w_nxt_out_valid = 1'b1;
        w_nxt_sum       = w_sum;
        if (in_last) begin
          w_nxt_out_last  = 1'b1;
          w_nxt_carry_out = w_c[DIGIT_W];
          w_nxt_ovf       = w_c[DIGIT_W-1] ^ w_c[DIGIT_W];
          w_nxt_state     = IDLE;
          w_nxt_count     = '0;
        end else begin
          w_nxt_state = BUSY;
          w_nxt_count = CNT_W'(1);
        end
      end else if (r_state == IDLE) begin
        w_nxt_frame_err = 1'b1;
      end else begin
        w_nxt_carry     = w_c[DIGIT_W];
        w_nxt_out_valid = 1'b1;
        w_nxt_sum       = w_sum;
        w_nxt_count     = w_count_inc[CNT_W-1:0];
        if (in_last || w_at_max) begin
          w_nxt_out_last  = 1'b1;
          w_nxt_carry_out = w_c[DIGIT_W];
          w_nxt_ovf       = w_c[DIGIT_W-1] ^ w_c[DIGIT_W];
          w_nxt_frame_err = !in_last;
          w_nxt_state     = IDLE;
          w_nxt_count     = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_carry     <= 1'b0;
      r_mode      <= c_MODE_ADD;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_frame_err <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_carry     <= w_nxt_carry;
      r_mode      <= w_nxt_mode;
      r_count     <= w_nxt_count;
      r_out_valid <= w_nxt_out_valid;
      r_out_last  <= w_nxt_out_last;
      r_sum       <= w_nxt_sum;
      r_carry_out <= w_nxt_carry_out;
      r_frame_err <= w_nxt_frame_err;
      r_ovf       <= w_nxt_ovf;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign frame_err = r_frame_err;

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = r_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_digit_serial_add_sub.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_digit_serial_add_sub                                          |
// | Purpose  : Directed self-checking bench for digit_serial_add_sub.           |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_digit_serial_add_sub;

  logic       clk;
  logic       rst;
  logic       in_valid, in_first, in_last, sub;
  logic [3:0] a, b;
  logic       out_valid, out_last, carry_out, frame_err;
  logic [3:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  digit_serial_add_sub #(
    .DIGIT_W    (4),
    .MAX_DIGITS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_last  (out_last),
    .sum       (sum),
    .carry_out (carry_out),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Packs {valid,last,sum,carry_out,frame_err} into one comparable word.
  function automatic logic [31:0] pk(input logic v, input logic l, input logic [3:0] s,
                                     input logic c, input logic e);
    return {24'd0, v, l, s, c, e};
  endfunction

  function automatic logic [31:0] obs_full();
    return {24'd0, out_valid, out_last, sum, carry_out, frame_err};
  endfunction

  // Control-only view for cycles where the sum digit is don't-care.
  function automatic logic [31:0] obs_ctl();
    return {28'd0, out_valid, out_last, carry_out, frame_err};
  endfunction

  task automatic beat(input logic v, input logic f, input logic l, input logic s,
                      input logic [3:0] aa, input logic [3:0] bb);
    @(negedge clk);
    in_valid = v; in_first = f; in_last = l; sub = s; a = aa; b = bb;
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    beat(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; sub = 1'b0;
    a = 4'h0; b = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", obs_full(), pk(0, 0, 4'h0, 0, 0));
`ifdef SERIAL_ADDER_OVF_EN
    check("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // 0xF3 + 0x0E = 0x101
    beat(1, 1, 0, 0, 4'h3, 4'hE);
    check("add_d0", obs_full(), pk(1, 0, 4'h1, 0, 0));
    beat(1, 0, 1, 0, 4'hF, 4'h0);
    check("add_d1", obs_full(), pk(1, 1, 4'h0, 1, 0));
`ifdef SERIAL_ADDER_OVF_EN
    check("add_ovf", {31'd0, ovf}, 32'd0);
`endif

    // 5 - 7 single beat: 0xE with borrow
    beat(1, 1, 1, 1, 4'h5, 4'h7);
    check("sub_single", obs_full(), pk(1, 1, 4'hE, 0, 0));
`ifdef SERIAL_ADDER_OVF_EN
    check("sub_single_ovf", {31'd0, ovf}, 32'd0);
`endif

    // 0x20 - 0x01 = 0x1F; sub deasserted on beat 2 must be ignored
    beat(1, 1, 0, 1, 4'h0, 4'h1);
    check("sub_d0", obs_full(), pk(1, 0, 4'hF, 0, 0));
    beat(1, 0, 1, 0, 4'h2, 4'h0);
    check("sub_d1_mode_hold", obs_full(), pk(1, 1, 4'h1, 1, 0));

    // 0x88 + 0x88 = 0x110 with three idle cycles between beats
    beat(1, 1, 0, 0, 4'h8, 4'h8);
    check("gap_d0", obs_full(), pk(1, 0, 4'h0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      gap();
      check("gap_idle", obs_ctl(), 32'h0);
    end
    beat(1, 0, 1, 0, 4'h8, 4'h8);
    check("gap_d1", obs_full(), pk(1, 1, 4'h1, 1, 0));
`ifdef SERIAL_ADDER_OVF_EN
    check("gap_ovf", {31'd0, ovf}, 32'd1);
`endif

    // Abort: new first while busy restarts with carry-in 0
    beat(1, 1, 0, 0, 4'hF, 4'h1);
    check("abort_old_d0", obs_full(), pk(1, 0, 4'h0, 0, 0));
    beat(1, 1, 0, 0, 4'h2, 4'h3);
    check("abort_new_d0", obs_full(), pk(1, 0, 4'h5, 0, 1));
    beat(1, 0, 1, 0, 4'h0, 4'h0);
    check("abort_new_d1", obs_full(), pk(1, 1, 4'h0, 0, 0));

    // Length limit of 2 digits reached without in_last
    beat(1, 1, 0, 0, 4'h1, 4'h1);
    check("max_d0", obs_full(), pk(1, 0, 4'h2, 0, 0));
    beat(1, 0, 0, 0, 4'hF, 4'h1);
    check("max_d1_forced_last", obs_full(), pk(1, 1, 4'h0, 1, 1));
    beat(1, 0, 0, 0, 4'h1, 4'h1);
    check("max_d2_dropped", obs_ctl(), 32'h1);
    gap();
    check("err_one_cycle", obs_ctl(), 32'h0);

    // Reset mid-frame, with a valid beat presented alongside rst
    beat(1, 1, 0, 0, 4'h1, 4'h1);
    check("rst_pre_d0", obs_full(), pk(1, 0, 4'h2, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    beat(1, 0, 1, 0, 4'h1, 4'h1);
    check("rst_outputs", obs_full(), pk(0, 0, 4'h0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    beat(1, 0, 1, 0, 4'h1, 4'h1);
    check("rst_then_drop", obs_ctl(), 32'h1);
    gap();
    check("rst_final_idle", obs_ctl(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
